// File: rtl/fifo_pkg.sv
// Shared FIFO defaults (widths, depth derivation, flag thresholds) and the
// push/pop event classification used by fifo_param.
package fifo_pkg;

   localparam int unsigned FIFO_DATA_WIDTH      = 10;
   localparam int unsigned FIFO_ADDR_WIDTH      = 3;
   localparam int unsigned FIFO_ALMOST_FULL_TH  = 6;
   localparam int unsigned FIFO_ALMOST_EMPTY_TH = 2;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic int unsigned fifo_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

   localparam int unsigned FIFO_DEPTH = fifo_depth(FIFO_ADDR_WIDTH);

endpackage

// File: rtl/memoria_ram_param.sv
// Two-port RAM: one write port, one registered read port. The array itself
// is not reset; only the read register is cleared.
module memoria_ram_param #(
   parameter int unsigned DATA_WIDTH = 10,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr_w,
   input  logic [DATA_WIDTH-1:0] data_w,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr_r,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr_w] <= data_w;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= '0;
      else if (re) q <= mem[addr_r];
   end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO over memoria_ram_param with registered read data.
// Define FIFO_ERR_EN to add the sticky overflow/underflow `error` output.
module fifo_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = FIFO_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH      = FIFO_ADDR_WIDTH,
   parameter int unsigned ALMOST_FULL_TH  = FIFO_ALMOST_FULL_TH,
   parameter int unsigned ALMOST_EMPTY_TH = FIFO_ALMOST_EMPTY_TH
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  push,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   fill_count
`ifdef FIFO_ERR_EN
   ,
   output logic                  error
`endif
);

   localparam int unsigned         DEPTH   = fifo_depth(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AF_C    = ALMOST_FULL_TH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AE_C    = ALMOST_EMPTY_TH[ADDR_WIDTH:0];

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  push_ok;
   logic                  pop_ok;
   fifo_op_e              op;

   // Acceptance depends only on registered flags, so push/pop never reach outputs combinationally.
   assign push_ok = push && !full;
   assign pop_ok  = pop  && !empty;

   always_comb begin
      op = OP_IDLE;
      if (push_ok && pop_ok) op = OP_BOTH;
      else if (push_ok)      op = OP_PUSH;
      else if (pop_ok)       op = OP_POP;
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= pop_ok;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case (op)
            OP_PUSH: count <= count + 1'b1;
            OP_POP:  count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   memoria_ram_param #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (reset_L),
      .we    (push_ok),
      .addr_w(wr_ptr),
      .data_w(data_in),
      .re    (pop_ok),
      .addr_r(rd_ptr),
      .q     (data_out)
   );

   assign fill_count   = count;
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

`ifdef FIFO_ERR_EN
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)                             error <= 1'b0;
      else if ((push && full) || (pop && empty)) error <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: vector table plus directed sequences.
// Error-flag checks are compiled in only when FIFO_ERR_EN is defined.
module tb_fifo_param;

   logic       clk;
   logic       reset_L;
   logic [9:0] data_in;
   logic       push;
   logic       pop;
   logic [9:0] data_out;
   logic       valid_out;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [3:0] fill_count;
`ifdef FIFO_ERR_EN
   logic       error;
`endif

   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;

   fifo_param #(
      .DATA_WIDTH(10),
      .ADDR_WIDTH(3),
      .ALMOST_FULL_TH(6),
      .ALMOST_EMPTY_TH(2)
   ) dut (
      .clk         (clk),
      .reset_L     (reset_L),
      .data_in     (data_in),
      .push        (push),
      .pop         (pop),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .fill_count  (fill_count)
`ifdef FIFO_ERR_EN
      ,
      .error       (error)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       push;
      logic       pop;
      logic [9:0] din;
      logic [9:0] exp_dout;
      logic       exp_valid;
      logic [3:0] exp_count;
      logic [3:0] exp_flags;   // {full, empty, almost_full, almost_empty}
      logic       exp_err;
   } vec_t;

   vec_t vt [17];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      else
         pass_cnt++;
   endtask

   task automatic step(input logic p, input logic q, input logic [9:0] d);
      push    = p;
      pop     = q;
      data_in = d;
      @(posedge clk);
      #1;
      push    = 1'b0;
      pop     = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_L = 1'b0;
      #2;
      reset_L = 1'b1;
   endtask

   task automatic chk_flags(input string name, input int unsigned c);
      chk({name, "_count"}, 16'(fill_count), 16'(c));
      chk({name, "_full"},  16'(full),         16'(c == 8));
      chk({name, "_empty"}, 16'(empty),        16'(c == 0));
      chk({name, "_af"},    16'(almost_full),  16'(c >= 6));
      chk({name, "_ae"},    16'(almost_empty), 16'(c <= 2));
   endtask

   initial begin
      reset_L = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      data_in = '0;

      vt[0]  = '{1'b1, 1'b0, 10'h3FF, 10'h000, 1'b0, 4'd1, 4'b0001, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 10'h2AA, 10'h000, 1'b0, 4'd2, 4'b0001, 1'b0};
      vt[2]  = '{1'b1, 1'b0, 10'h155, 10'h000, 1'b0, 4'd3, 4'b0000, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 10'h3E0, 10'h000, 1'b0, 4'd4, 4'b0000, 1'b0};
      vt[4]  = '{1'b0, 1'b1, 10'h000, 10'h3FF, 1'b1, 4'd3, 4'b0000, 1'b0};
      vt[5]  = '{1'b0, 1'b1, 10'h000, 10'h2AA, 1'b1, 4'd2, 4'b0001, 1'b0};
      vt[6]  = '{1'b0, 1'b1, 10'h000, 10'h155, 1'b1, 4'd1, 4'b0001, 1'b0};
      vt[7]  = '{1'b0, 1'b1, 10'h000, 10'h3E0, 1'b1, 4'd0, 4'b0101, 1'b0};
      vt[8]  = '{1'b0, 1'b0, 10'h000, 10'h3E0, 1'b0, 4'd0, 4'b0101, 1'b0};
      vt[9]  = '{1'b0, 1'b1, 10'h000, 10'h3E0, 1'b0, 4'd0, 4'b0101, 1'b1};
      vt[10] = '{1'b1, 1'b1, 10'h011, 10'h3E0, 1'b0, 4'd1, 4'b0001, 1'b1};
      vt[11] = '{1'b1, 1'b0, 10'h022, 10'h3E0, 1'b0, 4'd2, 4'b0001, 1'b1};
      vt[12] = '{1'b1, 1'b0, 10'h033, 10'h3E0, 1'b0, 4'd3, 4'b0000, 1'b1};
      vt[13] = '{1'b1, 1'b1, 10'h044, 10'h011, 1'b1, 4'd3, 4'b0000, 1'b1};
      vt[14] = '{1'b0, 1'b1, 10'h000, 10'h022, 1'b1, 4'd2, 4'b0001, 1'b1};
      vt[15] = '{1'b0, 1'b1, 10'h000, 10'h033, 1'b1, 4'd1, 4'b0001, 1'b1};
      vt[16] = '{1'b0, 1'b1, 10'h000, 10'h044, 1'b1, 4'd0, 4'b0101, 1'b1};

      // Reset state while reset_L is held low
      #3;
      chk("rst_dout",  16'(data_out),  16'h0);
      chk("rst_valid", 16'(valid_out), 16'h0);
      chk_flags("rst", 0);
`ifdef FIFO_ERR_EN
      chk("rst_err", 16'(error), 16'h0);
`endif
      @(negedge clk);
      reset_L = 1'b1;

      // Ordered write/read, underflow, simultaneous push/pop at 0 and 3
      for (int i = 0; i < 17; i++) begin
         step(vt[i].push, vt[i].pop, vt[i].din);
         chk($sformatf("vec%0d_dout", i),  16'(data_out),  16'(vt[i].exp_dout));
         chk($sformatf("vec%0d_valid", i), 16'(valid_out), 16'(vt[i].exp_valid));
         chk($sformatf("vec%0d_count", i), 16'(fill_count), 16'(vt[i].exp_count));
         chk($sformatf("vec%0d_flags", i),
             16'({full, empty, almost_full, almost_empty}), 16'(vt[i].exp_flags));
`ifdef FIFO_ERR_EN
         chk($sformatf("vec%0d_err", i), 16'(error), 16'(vt[i].exp_err));
`endif
      end

      // Fill and overflow
      do_reset();
`ifdef FIFO_ERR_EN
      chk("ovf_err_clr", 16'(error), 16'h0);
`endif
      for (int i = 1; i <= 9; i++) begin
         step(1'b1, 1'b0, 10'(i));
         chk_flags($sformatf("fill%0d", i), (i > 8) ? 8 : i);
      end
`ifdef FIFO_ERR_EN
      chk("ovf_err", 16'(error), 16'h1);
`endif
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b1, '0);
         chk($sformatf("drain%0d_dout", i),  16'(data_out),  16'(i));
         chk($sformatf("drain%0d_valid", i), 16'(valid_out), 16'h1);
         chk($sformatf("drain%0d_count", i), 16'(fill_count), 16'(8 - i));
      end
      step(1'b0, 1'b0, '0);
      chk("drain_valid_drop", 16'(valid_out), 16'h0);

      // Simultaneous push/pop while full
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'(10'h100 + i));
      chk("refill_full", 16'(full), 16'h1);
      step(1'b1, 1'b1, 10'h3AB);
      chk("pp_full_count", 16'(fill_count), 16'd7);
      chk("pp_full_dout",  16'(data_out),   16'h100);
      chk("pp_full_valid", 16'(valid_out),  16'h1);
      chk("pp_full_nfull", 16'(full),       16'h0);

      // Wrap-around and thresholds
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         step(1'b1, 1'b0, 10'(10'h200 + i));
         chk_flags($sformatf("wrA_push%0d", i), i);
      end
      for (int i = 1; i <= 6; i++) begin
         step(1'b0, 1'b1, '0);
         chk($sformatf("wrA_pop%0d", i), 16'(data_out), 16'(10'h200 + i));
         chk_flags($sformatf("wrA_pop%0d", i), 6 - i);
      end
      for (int i = 1; i <= 7; i++) begin
         step(1'b1, 1'b0, 10'(10'h280 + i));
         chk_flags($sformatf("wrB_push%0d", i), i);
      end
      for (int i = 1; i <= 7; i++) begin
         step(1'b0, 1'b1, '0);
         chk($sformatf("wrB_pop%0d", i),   16'(data_out),  16'(10'h280 + i));
         chk($sformatf("wrB_valid%0d", i), 16'(valid_out), 16'h1);
      end
      chk_flags("wrB_end", 0);

      // Reset mid-operation with a pop in flight
      do_reset();
      for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 10'(10'h0F0 + i));
      step(1'b0, 1'b1, '0);
      chk("mid_pre_valid", 16'(valid_out), 16'h1);
      chk("mid_pre_dout",  16'(data_out),  16'h0F1);
      #2;
      reset_L = 1'b0;
      #1;
      chk("mid_rst_valid", 16'(valid_out), 16'h0);
      chk("mid_rst_dout",  16'(data_out),  16'h0);
      chk_flags("mid_rst", 0);
`ifdef FIFO_ERR_EN
      chk("mid_rst_err", 16'(error), 16'h0);
`endif
      #1;
      reset_L = 1'b1;
      step(1'b1, 1'b0, 10'h001);
      chk_flags("mid_push", 1);
      step(1'b0, 1'b1, '0);
      chk("mid_pop_dout",  16'(data_out),  16'h001);
      chk("mid_pop_valid", 16'(valid_out), 16'h1);
      chk_flags("mid_pop", 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO built on a two-port RAM, replacing direct use of the fixed 10-bit × 8 memory by producers and consumers. It accepts pushes and pops in the same clock domain and returns popped data through a registered read port with a one-cycle `valid_out` strobe. It also reports full, empty, almost-full, almost-empty and fill level. It sits between the packet-forming logic and the downstream arbiter.

## Interface
- `DATA_WIDTH`, 10: word width in bits.
- `ADDR_WIDTH`, 3: address width; depth `DEPTH = 2**ADDR_WIDTH` (8).
- `ALMOST_FULL_TH`, 6: `almost_full` asserts when fill ≥ this value.
- `ALMOST_EMPTY_TH`, 2: `almost_empty` asserts when fill ≤ this value.

- `clk`  in  1  single clock, all state on rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `data_in`  in  DATA_WIDTH  word to push.
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `data_out`  out  DATA_WIDTH  registered read data.
- `valid_out`  out  1  `data_out` holds a freshly popped word this cycle.
- `full`  out  1  fill == DEPTH.
- `empty`  out  1  fill == 0.
- `almost_full`  out  1  fill ≥ ALMOST_FULL_TH.
- `almost_empty`  out  1  fill ≤ ALMOST_EMPTY_TH.
- `fill_count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `error`  out  1  sticky overflow/underflow flag; present only with `FIFO_ERR_EN`.

## Operation
- State:
  - write pointer `wr_ptr`, ADDR_WIDTH bits;
  - read pointer `rd_ptr`, ADDR_WIDTH bits;
  - counter `count`, ADDR_WIDTH+1 bits.
- Pointers wrap modulo DEPTH with natural overflow; no extra wrap bit.
- Accepted push: `push && !full`. Writes `data_in` to `mem[wr_ptr]` and increments `wr_ptr`.
- Accepted pop: `pop && !empty`. Reads `mem[rd_ptr]` into `data_out` and increments `rd_ptr`.
- Push while full and pop while empty are rejected. Pointers, count and memory are unchanged.
- Count update by accepted events:
  - push only: +1;
  - pop only: −1;
  - both: unchanged;
  - neither: unchanged.
- Simultaneous push and pop:
  - empty: push accepted, pop rejected, count goes to 1;
  - full: pop accepted, push rejected, count goes to DEPTH−1;
  - otherwise both accepted, count unchanged.
- Flags are pure decodes of the registered `count`; they update in the cycle after the event.
- `data_out` holds its last value when no pop is accepted.
- Memory contents are not reset. A read returns only words written since reset.

## Timing
- Reset (`reset_L` low, takes effect immediately, independent of `clk`):
  - `wr_ptr`, `rd_ptr`, `count`, `fill_count` = 0;
  - `data_out` = 0, `valid_out` = 0;
  - `empty` = 1, `almost_empty` = 1;
  - `full` = 0, `almost_full` = 0;
  - `error` = 0.
- Reset mid-operation: a pending `valid_out` is dropped and stored data is discarded logically (pointers cleared).
- Write latency: a word pushed at edge N is poppable at edge N+1, since `empty` deasserts after edge N.
- Read latency: pop accepted at edge N gives `data_out` valid and `valid_out` = 1 during cycle N→N+1. `valid_out` is a one-cycle pulse per accepted pop.
- Back-to-back pops produce `valid_out` high on consecutive cycles.
- No combinational path from `push`/`pop` to any output.

## Configuration
- `FIFO_ERR_EN` defined:
  - `error` port exists;
  - `error` sets on a rejected push (push while full) or rejected pop (pop while empty);
  - once set, it holds until `reset_L` is asserted.
- `FIFO_ERR_EN` undefined: `error` port and its register are absent, and rejected operations are silently dropped.

## Structure
- Package `fifo_pkg`:
  - default `DATA_WIDTH` / `ADDR_WIDTH` constants;
  - the `DEPTH` derivation;
  - default threshold constants shared with the arbiter.
- One sub-module, `memoria_ram_param`:
  - parametrised DATA_WIDTH × 2**ADDR_WIDTH;
  - one write port (`we`, `addr_w`, `data_w`);
  - one registered read port (`re`, `addr_r`, `q`);
  - no reset on the array.
- `fifo_param` owns the pointers, count, flags, `valid_out` and `error`.

## Test plan
- Ordered write/read: after reset, push 10'h3FF, 10'h2AA, 10'h155, 10'h3E0 on consecutive cycles, then 4 pops. Required: `data_out` shows the same order, one cycle after each pop, `valid_out` high 4 cycles, `fill_count` 4→0, `empty`=1.
- Fill and overflow: 9 consecutive pushes of 1..9. Required: `full`=1 and `fill_count`=8 after the 8th push; the 9th push is dropped; `error`=1 with `FIFO_ERR_EN`. Draining then yields 1..8.
- Underflow: pop on an empty FIFO. Required: `valid_out`=0, `data_out` unchanged, `fill_count`=0, `error`=1 with `FIFO_ERR_EN`.
- Simultaneous push and pop:
  - at count 3: count stays 3 and the oldest word is output;
  - at count 0: count becomes 1, `valid_out`=0;
  - at count 8: count becomes 7.
- Wrap-around and thresholds: push 6, pop 6, push 7, pop 7. Required: correct data order across the pointer wrap. `almost_full` rises when count reaches 6; `almost_empty` falls when count reaches 3.
- Reset mid-operation: with count=5 and a pop in flight, pull `reset_L` low between clock edges. Required: all outputs take their reset values immediately. After release, a push of 10'h001 followed by a pop returns 10'h001.
